// File: rtl/x_corr_engine_if.sv
// rtl/x_corr_engine_if.sv - sample-in / result-out handshake bundle for x_corr_engine
interface x_corr_engine_if #(
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int length_counter_bits = 4,
    parameter int out_max_bits        = 32
);
    logic                           m_axis_tvalid;
    logic                           s_axis_tready;
    logic signed [xi_bits-1:0]      xi;
    logic signed [xq_bits-1:0]      xq;
    logic signed [yi_bits-1:0]      yi;
    logic signed [yq_bits-1:0]      yq;
    logic                           s_axis_tvalid;
    logic                           m_axis_tready;
    logic [out_max_bits-1:0]        out_max;
    logic [length_counter_bits-1:0] index;

    modport master (
        output m_axis_tvalid, xi, xq, yi, yq, m_axis_tready,
        input  s_axis_tready, s_axis_tvalid, out_max, index
    );

    modport slave (
        input  m_axis_tvalid, xi, xq, yi, yq, m_axis_tready,
        output s_axis_tready, s_axis_tvalid, out_max, index
    );
endinterface

// File: rtl/x_corr_engine.sv
// rtl/x_corr_engine.sv - complex cross-correlator with per-frame peak search
// Optional X_CORR_SQ_MAG_EN selects I^2+Q^2 magnitude (one extra stage) instead of |I|+|Q|.
module x_corr_engine #(
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int i_bits              = 32,
    parameter int q_bits              = 32,
    parameter int length              = 16,
    parameter int length_counter_bits = 4,
    parameter int out_max_bits        = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    x_corr_engine_if.slave bus
);
    localparam int XW = (xi_bits > xq_bits) ? xi_bits : xq_bits;
    localparam int YW = (yi_bits > yq_bits) ? yi_bits : yq_bits;
    localparam int PW = XW + YW;
    localparam int CW = length_counter_bits;
    localparam logic [CW-1:0] LAST = CW'(length - 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic          ready, accept, frame_clr, last_smp, last_lag;
    logic [CW-1:0] smp_cnt, lag_cnt;

    assign ready     = (state_q == RUN);
    assign accept    = bus.m_axis_tvalid && ready;
    assign frame_clr = (state_q == DONE) && bus.m_axis_tready;
    assign last_smp  = (smp_cnt == LAST);
    assign last_lag  = (lag_cnt == LAST);

    assign bus.s_axis_tready = ready;
    assign bus.s_axis_tvalid = (state_q == DONE);

    logic signed [PW-1:0] p_ii, p_qq, p_qi, p_iq;
    assign p_ii = PW'(bus.xi) * PW'(bus.yi);
    assign p_qq = PW'(bus.xq) * PW'(bus.yq);
    assign p_qi = PW'(bus.xq) * PW'(bus.yi);
    assign p_iq = PW'(bus.xi) * PW'(bus.yq);

    // Stage 1: product register, tagged with lag position
    logic                     p_vld, p_close, p_final;
    logic [CW-1:0]            p_lag;
    logic signed [i_bits-1:0] p_i;
    logic signed [q_bits-1:0] p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt <= '0;
            lag_cnt <= '0;
            p_vld   <= 1'b0;
            p_close <= 1'b0;
            p_final <= 1'b0;
            p_lag   <= '0;
            p_i     <= '0;
            p_q     <= '0;
        end else begin
            p_vld <= accept;
            if (accept) begin
                p_i     <= i_bits'(p_ii) + i_bits'(p_qq);
                p_q     <= q_bits'(p_qi) - q_bits'(p_iq);
                p_close <= last_smp;
                p_final <= last_smp && last_lag;
                p_lag   <= lag_cnt;
            end
            if (frame_clr) begin
                smp_cnt <= '0;
                lag_cnt <= '0;
            end else if (accept) begin
                if (last_smp) begin
                    smp_cnt <= '0;
                    lag_cnt <= lag_cnt + 1'b1;
                end else begin
                    smp_cnt <= smp_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 2: accumulate; a closing sample hands the lag sum onward and clears the accumulator
    logic signed [i_bits-1:0] acc_i, a_i;
    logic signed [q_bits-1:0] acc_q, a_q;
    logic                     a_vld, a_final;
    logic [CW-1:0]            a_lag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i   <= '0;
            acc_q   <= '0;
            a_i     <= '0;
            a_q     <= '0;
            a_vld   <= 1'b0;
            a_final <= 1'b0;
            a_lag   <= '0;
        end else begin
            a_vld <= p_vld && p_close;
            if (frame_clr) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (p_vld) begin
                if (p_close) begin
                    a_i     <= acc_i + p_i;
                    a_q     <= acc_q + p_q;
                    a_lag   <= p_lag;
                    a_final <= p_final;
                    acc_i   <= '0;
                    acc_q   <= '0;
                end else begin
                    acc_i <= acc_i + p_i;
                    acc_q <= acc_q + p_q;
                end
            end
        end
    end

`ifdef X_CORR_SQ_MAG_EN
    localparam int SQI_W = 2 * i_bits;
    localparam int SQQ_W = 2 * q_bits;
    localparam int MAG_W = ((SQI_W > SQQ_W) ? SQI_W : SQQ_W) + 1;

    logic [SQI_W-1:0] s_ii;
    logic [SQQ_W-1:0] s_qq;
    logic             s_vld, s_final;
    logic [CW-1:0]    s_lag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ii    <= '0;
            s_qq    <= '0;
            s_vld   <= 1'b0;
            s_final <= 1'b0;
            s_lag   <= '0;
        end else begin
            s_vld   <= a_vld;
            s_ii    <= SQI_W'(a_i) * SQI_W'(a_i);
            s_qq    <= SQQ_W'(a_q) * SQQ_W'(a_q);
            s_final <= a_final;
            s_lag   <= a_lag;
        end
    end

    logic [MAG_W-1:0] mag_full;
    logic             mag_vld, mag_final;
    logic [CW-1:0]    mag_lag;
    assign mag_full  = MAG_W'(s_ii) + MAG_W'(s_qq);
    assign mag_vld   = s_vld;
    assign mag_final = s_final;
    assign mag_lag   = s_lag;
`else
    localparam int MAG_W = ((i_bits > q_bits) ? i_bits : q_bits) + 1;

    logic [i_bits-1:0] abs_i;
    logic [q_bits-1:0] abs_q;
    assign abs_i = a_i[i_bits-1] ? -a_i : a_i;
    assign abs_q = a_q[q_bits-1] ? -a_q : a_q;

    logic [MAG_W-1:0] mag_full;
    logic             mag_vld, mag_final;
    logic [CW-1:0]    mag_lag;
    assign mag_full  = MAG_W'(abs_i) + MAG_W'(abs_q);
    assign mag_vld   = a_vld;
    assign mag_final = a_final;
    assign mag_lag   = a_lag;
`endif

    localparam int EXT_W = (MAG_W > out_max_bits) ? MAG_W : out_max_bits;
    logic [EXT_W-1:0]        mag_ext, mag_lim;
    logic [out_max_bits-1:0] mag_sat;
    assign mag_ext = EXT_W'(mag_full);
    assign mag_lim = EXT_W'({out_max_bits{1'b1}});
    assign mag_sat = (mag_ext > mag_lim) ? mag_lim[out_max_bits-1:0] : mag_ext[out_max_bits-1:0];

    // Stage 3: registered saturated magnitude
    logic [out_max_bits-1:0] m_mag;
    logic                    m_vld, m_final;
    logic [CW-1:0]           m_lag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mag   <= '0;
            m_vld   <= 1'b0;
            m_final <= 1'b0;
            m_lag   <= '0;
        end else begin
            m_vld   <= mag_vld;
            m_mag   <= mag_sat;
            m_final <= mag_vld && mag_final;
            m_lag   <= mag_lag;
        end
    end

    // Strict compare keeps the earliest lag on ties
    logic [out_max_bits-1:0] run_max, best_max, res_max;
    logic [CW-1:0]           run_idx, best_idx, res_idx;
    logic                    better;
    assign better   = (m_mag > run_max);
    assign best_max = better ? m_mag : run_max;
    assign best_idx = better ? m_lag : run_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max <= '0;
            run_idx <= '0;
            res_max <= '0;
            res_idx <= '0;
        end else if (frame_clr) begin
            run_max <= '0;
            run_idx <= '0;
        end else if (m_vld) begin
            run_max <= best_max;
            run_idx <= best_idx;
            if (m_final) begin
                res_max <= best_max;
                res_idx <= best_idx;
            end
        end
    end

    assign bus.out_max = res_max;
    assign bus.index   = res_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && last_smp && last_lag) state_d = DRAIN;
            DRAIN:   if (m_vld && m_final)              state_d = DONE;
            DONE:    if (bus.m_axis_tready)             state_d = RUN;
            default: state_d = RUN;
        endcase
    end
endmodule

// File: tb/tb_x_corr_engine.sv
// tb/tb_x_corr_engine.sv - directed scoreboard bench for x_corr_engine (length 4, L1 magnitude)
module tb_x_corr_engine;
    localparam int XB  = 12;
    localparam int LEN = 4;
    localparam int CB  = 4;
    localparam int OB  = 32;
    localparam int NS  = LEN * LEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    x_corr_engine_if #(.xi_bits(XB), .xq_bits(XB), .yi_bits(XB), .yq_bits(XB),
                       .length_counter_bits(CB), .out_max_bits(OB)) bus ();

    x_corr_engine #(.xi_bits(XB), .xq_bits(XB), .yi_bits(XB), .yq_bits(XB),
                    .i_bits(32), .q_bits(32), .length(LEN),
                    .length_counter_bits(CB), .out_max_bits(OB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_max_q[$];
    int exp_idx_q[$];
    int prev_max = 0;
    int prev_idx = 0;
    int f_xi[NS], f_xq[NS], f_yi[NS], f_yq[NS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one compare per result handshake
    always @(negedge clk) begin
        if (rst_n && bus.s_axis_tvalid && bus.m_axis_tready) begin
            if (exp_max_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                check("sb_out_max", bus.out_max, 64'(exp_max_q.pop_front()));
                check("sb_index", bus.index, 64'(exp_idx_q.pop_front()));
            end
        end
    end

    // sel < 0: y applied to every lag; otherwise y only in lag sel, zero elsewhere
    task automatic fill(input int sel, input int xi, input int xq, input int yi, input int yq);
        for (int i = 0; i < NS; i++) begin
            f_xi[i] = xi;
            f_xq[i] = xq;
            f_yi[i] = (sel < 0 || i / LEN == sel) ? yi : 0;
            f_yq[i] = (sel < 0 || i / LEN == sel) ? yq : 0;
        end
    endtask

    task automatic send(input int i);
        bus.xi = XB'(f_xi[i]);
        bus.xq = XB'(f_xq[i]);
        bus.yi = XB'(f_yi[i]);
        bus.yq = XB'(f_yq[i]);
        bus.m_axis_tvalid = 1'b1;
        @(negedge clk);
        check("ready_run", bus.s_axis_tready, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit gap, input bit hold, input int emax, input int eidx);
        exp_max_q.push_back(emax);
        exp_idx_q.push_back(eidx);
        bus.m_axis_tready = !hold;
        for (int i = 0; i < NS; i++) begin
            send(i);
            if (gap && i < NS - 1) begin
                bus.m_axis_tvalid = 1'b0;
                @(negedge clk);
                check("ready_gap", bus.s_axis_tready, 64'd1);
                @(posedge clk);
                #1;
            end
        end
        check("ready_drop", bus.s_axis_tready, 64'd0);
        // junk presented while not ready must be ignored
        bus.xi = XB'(7);
        bus.yi = XB'(7);
        bus.m_axis_tvalid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("latency_tvalid", bus.s_axis_tvalid, 64'(k == 3));
            if (k == 2) check("hold_prev_max", bus.out_max, 64'(prev_max));
        end
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                check("stall_tvalid", bus.s_axis_tvalid, 64'd1);
                check("stall_out_max", bus.out_max, 64'(emax));
                check("stall_index", bus.index, 64'(eidx));
                check("stall_ready", bus.s_axis_tready, 64'd0);
            end
        end
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_ready", bus.s_axis_tready, 64'd1);
        check("post_hs_tvalid", bus.s_axis_tvalid, 64'd0);
        prev_max = emax;
        prev_idx = eidx;
    endtask

    initial begin
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.xi = '0;
        bus.xq = '0;
        bus.yi = '0;
        bus.yq = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.s_axis_tready, 64'd1);
        check("rst_tvalid", bus.s_axis_tvalid, 64'd0);
        check("rst_out_max", bus.out_max, 64'd0);
        check("rst_index", bus.index, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill(-1, 1, 0, 1, 0);   run_frame(1'b0, 1'b0, 4, 0);
        fill(2, 1, 0, 1, 0);    run_frame(1'b0, 1'b0, 4, 2);
        fill(-1, 0, 1, 1, 0);   run_frame(1'b0, 1'b0, 4, 0);
        fill(-1, 2, 0, -3, 0);  run_frame(1'b0, 1'b0, 24, 0);
        fill(-1, 1, 0, 1, 0);   run_frame(1'b1, 1'b0, 4, 0);
        fill(-1, 2, 0, -3, 0);  run_frame(1'b0, 1'b1, 24, 0);
        fill(2, 1, 0, 1, 0);    run_frame(1'b0, 1'b0, 4, 2);

        fill(-1, 1, 0, 1, 0);
        for (int i = 0; i < 7; i++) send(i);
        bus.m_axis_tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", bus.s_axis_tready, 64'd1);
        check("arst_tvalid", bus.s_axis_tvalid, 64'd0);
        check("arst_out_max", bus.out_max, 64'd0);
        check("arst_index", bus.index, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_max = 0;
        prev_idx = 0;
        fill(3, 1, 1, 1, -1);   run_frame(1'b0, 1'b0, 8, 3);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_max_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/x_corr_engine.md
# x_corr_engine

Complex cross-correlator with peak search. It accumulates `length` complex products `x·conj(y)` per lag over `length` consecutive lags, then reports the largest correlation magnitude and the lag index where it occurred. It sits behind each frequency-shift branch of the CAF (cross-ambiguity function) engine: reference samples drive x and frequency-shifted capture samples drive y.

## Interface
- `xi_bits`, default 12: signed width of reference I.
- `xq_bits`, default 12: signed width of reference Q.
- `yi_bits`, default 12: signed width of capture I.
- `yq_bits`, default 12: signed width of capture Q.
- `i_bits`, default 32: signed width of the I accumulator.
- `q_bits`, default 32: signed width of the Q accumulator.
- `length`, default 16: samples per lag, and number of lags per frame; must be ≥2.
- `length_counter_bits`, default 4: width of sample/lag counters and `index`; must satisfy 2^bits ≥ `length`.
- `out_max_bits`, default 32: width of magnitude/peak.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `m_axis_tvalid` input 1: x/y sample pair valid.
- `s_axis_tready` output 1: engine accepts a sample pair.
- `xi`, `xq` input `xi_bits`/`xq_bits`: reference sample, two's complement.
- `yi`, `yq` input `yi_bits`/`yq_bits`: capture sample, two's complement.
- `s_axis_tvalid` output 1: frame result valid.
- `m_axis_tready` input 1: consumer accepts result.
- `out_max` output `out_max_bits`: peak magnitude of the frame.
- `index` output `length_counter_bits`: lag (0..`length`-1) of the peak.

## Operation
- States: RUN, DRAIN, DONE. Reset enters RUN with all counters, accumulators and the running max cleared.
- RUN: `s_axis_tready`=1. Sample accepted when `m_axis_tvalid && s_axis_tready`. Gaps in `m_axis_tvalid` stall the engine with no loss of state.
- Per accepted sample: I += xi·yi + xq·yq; Q += xq·yi − xi·yq. Products are full precision, sign-extended to `i_bits`/`q_bits`; the accumulator wraps in two's complement. Integration sets widths to avoid overflow: ≥ x+y+1+clog2(`length`).
- After `length` samples, the lag closes. mag = |I|+|Q|, saturated to 2^`out_max_bits`−1. If mag > running max (strict), the running max becomes mag and `index` becomes the lag number. Ties keep the earlier lag. Then I, Q and the sample count clear and the lag counter increments.
- The last sample of lag `length`-1 moves the engine to DRAIN, with `s_axis_tready`=0. When the final compare completes, it moves to DONE.
- DONE: `s_axis_tvalid`=1, and `out_max`/`index` hold steady. Handshake is `s_axis_tvalid && m_axis_tready` on a rising edge. On the next edge the engine clears all state and the running max, returns to RUN, and sets `s_axis_tready`=1.
- `out_max`/`index` update only at frame end. Between frames they hold the last reported result.

## Timing
- Reset values: `s_axis_tready`=1, `s_axis_tvalid`=0, `out_max`=0, `index`=0. Reset takes effect immediately and asynchronously.
- Reset mid-frame discards the partial frame. The first sample after release counts as lag 0, sample 0.
- Pipeline: product register (1 cycle), then accumulate (1 cycle), then magnitude+compare (1 cycle).
- `s_axis_tvalid` rises exactly 3 rising edges after the edge that accepted the final sample of the frame.
- `s_axis_tready` drops on the edge that accepts the final sample. It returns to 1 on the edge after the result handshake.
- If `m_axis_tready` is already 1 when `s_axis_tvalid` rises, the handshake completes on that first valid cycle.
- Inputs are ignored whenever `s_axis_tready`=0.

## Configuration
- `X_CORR_SQ_MAG_EN` defined: mag = I²+Q², computed at full precision and then saturated to `out_max_bits`. This adds one pipeline stage, so `s_axis_tvalid` rises 4 edges after the final sample.
- `X_CORR_SQ_MAG_EN` undefined: L1 magnitude |I|+|Q| with 3-edge latency, as specified above.

## Test plan
- Bench uses `length`=4, 4-bit counters, macro undefined.
- Continuous stream: 16 pairs with x=(1,0), y=(1,0). Required: `out_max`=4, `index`=0 (tie rule), `s_axis_tvalid` 3 edges after the 16th accept.
- y=(1,0) only in lag 2, zero in all other lags, x=(1,0). Required: `out_max`=4, `index`=2.
- x=(0,1), y=(1,0) for all 16 samples. Required: Q=4 per lag, `out_max`=4; x=(2,0), y=(−3,0) gives `out_max`=24.
- Same stream as the first scenario, with `m_axis_tvalid` low every other cycle. Required: identical result; `s_axis_tready` stays 1 until the 16th accept.
- Hold `m_axis_tready`=0 for 5 cycles after valid. Required: `s_axis_tvalid`/`out_max`/`index` stable and `s_axis_tready`=0. After the handshake, `s_axis_tready`=1 and the next frame starts at lag 0.
- Pulse `rst_n` low after 7 samples. Required: outputs return to reset values at once; a fresh 16-sample frame gives the correct result.
